// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encoding, default widths and depth/count derivation for the FIFO controller
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 3;
  typedef enum logic [2:0] {
    INIT   = 3'd0,
    NO_OP  = 3'd1,
    WRITE  = 3'd2,
    WR_ERR = 3'd3,
    READ   = 3'd4,
    RD_ERR = 3'd5
  } state_t;
  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/fifo_next_state.sv
// fifo_next_state: combinational next-state, pointer and occupancy decode for fifo_ctrl
module fifo_next_state
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic [ADDR_WIDTH-1:0] head,
  input  logic [ADDR_WIDTH-1:0] tail,
  output state_t                next_state,
  output logic                  push,
  output logic                  pop,
  output logic [ADDR_WIDTH-1:0] head_nxt,
  output logic [ADDR_WIDTH-1:0] tail_nxt,
  output logic [ADDR_WIDTH:0]   count_nxt
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(depth(ADDR_WIDTH));
  logic wr_only, rd_only;
  always_comb begin
    wr_only    = wr_en & ~rd_en;
    rd_only    = rd_en & ~wr_en;
    push       = wr_only & (count < DEPTH);
    pop        = rd_only & (count != '0);
    next_state = wr_only ? (push ? WRITE : WR_ERR) : rd_only ? (pop ? READ : RD_ERR) : NO_OP;
    head_nxt   = head + ADDR_WIDTH'(push);
    tail_nxt   = tail + ADDR_WIDTH'(pop);
    count_nxt  = count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
  end
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: register-file FIFO controller holding pointers, occupancy, status and popped-word capture
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wAddr,
  output logic [DATA_WIDTH-1:0] wData,
  output logic [ADDR_WIDTH-1:0] rAddr,
  input  logic [DATA_WIDTH-1:0] rData
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(depth(ADDR_WIDTH));
  state_t                state, next_state;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] head, tail, head_nxt, tail_nxt;
  logic [ADDR_WIDTH:0]   count_nxt;
  fifo_next_state #(.ADDR_WIDTH(ADDR_WIDTH)) u_next (
    .wr_en(wr_en),
    .rd_en(rd_en),
    .count(data_count),
    .head(head),
    .tail(tail),
    .next_state(next_state),
    .push(push),
    .pop(pop),
    .head_nxt(head_nxt),
    .tail_nxt(tail_nxt),
    .count_nxt(count_nxt)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      rAddr      <= '0;
      d_out      <= '0;
    end else begin
      state      <= next_state;
      head       <= head_nxt;
      tail       <= tail_nxt;
      data_count <= count_nxt;
      we         <= push;
      if (push) begin
        wAddr <= head;
        wData <= d_in;
      end
      if (pop) rAddr <= tail;
      if (state == READ) d_out <= rData;
    end
  end
  assign full   = data_count == DEPTH;
  assign empty  = data_count == '0;
  assign wr_ack = state == WRITE;
  assign wr_err = state == WR_ERR;
  assign rd_ack = state == READ;
  assign rd_err = state == RD_ERR;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed stimulus against a queue-based FIFO model with per-cycle comparison
module tb_fifo_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] d_in = '0, d_out, wData, rData;
  logic        full, empty, wr_ack, wr_err, rd_ack, rd_err, we;
  logic [3:0]  data_count;
  logic [2:0]  wAddr, rAddr;
  logic [31:0] mem [8];
  int          vectors = 0, miscompares = 0;
  logic [31:0] q[$];
  int          m_push_n, m_pop_n;
  logic [31:0] e_dout, e_wdata, pend;
  logic [2:0]  e_waddr, e_raddr;
  bit          pend_v, e_we, e_wack, e_werr, e_rack, e_rerr;
  bit          model_ok = 0;
  fifo_ctrl dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .d_in(d_in), .d_out(d_out),
    .full(full), .empty(empty), .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack),
    .rd_err(rd_err), .data_count(data_count), .we(we), .wAddr(wAddr), .wData(wData),
    .rAddr(rAddr), .rData(rData)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (we) mem[wAddr] <= wData;
  assign rData = mem[rAddr];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(input bit rs, input bit w, input bit r, input logic [31:0] d);
    reset = rs;
    wr_en = w;
    rd_en = r;
    d_in  = d;
    @(posedge clk);
    {e_we, e_wack, e_werr, e_rack, e_rerr} = '0;
    if (rs) begin
      q.delete();
      m_push_n = 0;
      m_pop_n  = 0;
      e_dout   = '0;
      e_wdata  = '0;
      e_waddr  = '0;
      e_raddr  = '0;
      pend_v   = 0;
      model_ok = 1;
    end else begin
      if (pend_v) e_dout = pend;
      pend_v = 0;
      if (w && !r) begin
        if (q.size() < 8) begin
          q.push_back(d);
          e_we    = 1;
          e_wack  = 1;
          e_waddr = 3'(m_push_n);
          e_wdata = d;
          m_push_n++;
        end else e_werr = 1;
      end else if (r && !w) begin
        if (q.size() > 0) begin
          pend    = q.pop_front();
          pend_v  = 1;
          e_rack  = 1;
          e_raddr = 3'(m_pop_n);
          m_pop_n++;
        end else e_rerr = 1;
      end
    end
    #1;
  endtask
  always @(negedge clk) if (model_ok) begin
    chk("data_count", 32'(data_count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == 8));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("d_out", d_out, e_dout);
    chk("we", 32'(we), 32'(e_we));
    chk("wAddr", 32'(wAddr), 32'(e_waddr));
    chk("wData", wData, e_wdata);
    chk("rAddr", 32'(rAddr), 32'(e_raddr));
    chk("wr_ack", 32'(wr_ack), 32'(e_wack));
    chk("wr_err", 32'(wr_err), 32'(e_werr));
    chk("rd_ack", 32'(rd_ack), 32'(e_rack));
    chk("rd_err", 32'(rd_err), 32'(e_rerr));
  end
  initial begin
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("t1 empty", 32'(empty), 32'd1);
    chk("t1 full", 32'(full), 32'd0);
    chk("t1 d_out", d_out, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 32'h11111111 * 32'(i + 1));
      chk("t2 wAddr", 32'(wAddr), 32'(i));
      chk("t2 wr_ack", 32'(wr_ack), 32'd1);
    end
    chk("t2 count", 32'(data_count), 32'd8);
    chk("t2 full", 32'(full), 32'd1);
    step(0, 1, 0, 32'hDEADBEEF);
    chk("t2 wr_err", 32'(wr_err), 32'd1);
    chk("t2 we", 32'(we), 32'd0);
    chk("t2 count hold", 32'(data_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0);
      if (i > 0) chk("t3 d_out", d_out, 32'h11111111 * 32'(i));
    end
    step(0, 0, 0, 0);
    chk("t3 d_out last", d_out, 32'h88888888);
    chk("t3 empty", 32'(empty), 32'd1);
    step(0, 0, 1, 0);
    chk("t3 rd_err", 32'(rd_err), 32'd1);
    chk("t3 d_out hold", d_out, 32'h88888888);
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 32'hA0 + 32'(i));
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 32'hB0 + 32'(i));
      chk("t4 wAddr", 32'(wAddr), 32'((6 + i) % 8));
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      chk("t4 rAddr", 32'(rAddr), 32'((6 + i) % 8));
    end
    step(0, 0, 0, 0);
    chk("t4 d_out", d_out, 32'hB3);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'hC0 + 32'(i));
    step(0, 1, 1, 32'hFFFF0000);
    chk("t5 count", 32'(data_count), 32'd3);
    chk("t5 wr_ack", 32'(wr_ack), 32'd0);
    chk("t5 rd_ack", 32'(rd_ack), 32'd0);
    chk("t5 we", 32'(we), 32'd0);
    chk("t5 wAddr", 32'(wAddr), 32'd2);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("t5 d_out", d_out, 32'hC0);
    step(0, 1, 0, 32'h12345678);
    step(1, 0, 0, 0);
    chk("t6 we", 32'(we), 32'd0);
    chk("t6 count", 32'(data_count), 32'd0);
    chk("t6 empty", 32'(empty), 32'd1);
    step(0, 1, 0, 32'h55AA55AA);
    step(0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0);
    chk("t6 push-pop d_out", d_out, 32'h55AA55AA);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
